// File: rtl/mem_stage_resp.sv
//==============================================================================
// Module   : mem_stage_resp
// Purpose  : MEM pipeline stage between EXE and WB. Waits for the data-SRAM
//            response of a request already issued by EXE. Aligns and sign- or
//            zero-extends load data, buffers a response that arrives while WB
//            is stalled, and counts/drops responses that belong to
//            instructions killed by a flush. Provides forwarding and
//            exception status upstream.
// Ports    : clk, resetn (sync, active-low), flush
//            EXE side : exe_to_mem_valid, mem_allowin, exe_pc, exe_result,
//                       exe_mem_op, exe_is_load, exe_req_sent, exe_rf_we,
//                       exe_rf_waddr, exe_side
//            SRAM     : data_sram_data_ok, data_sram_rdata
//            WB side  : wb_allowin, mem_to_wb_valid, mem_to_wb_pc, mem_rf_we,
//                       mem_rf_waddr, mem_rf_wdata, mem_side
//            Upstream : mem_fwd {valid&we, stall_load, waddr, wdata}, mem_ex
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_stage_resp #(
   parameter int SIDE_W      = 79,
   parameter int MAX_DISCARD = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              exe_to_mem_valid,
   output logic              mem_allowin,
   input  logic [31:0]       exe_pc,
   input  logic [31:0]       exe_result,
   input  logic [3:0]        exe_mem_op,
   input  logic              exe_is_load,
   input  logic              exe_req_sent,
   input  logic              exe_rf_we,
   input  logic [4:0]        exe_rf_waddr,
   input  logic [SIDE_W-1:0] exe_side,
   input  logic              data_sram_data_ok,
   input  logic [31:0]       data_sram_rdata,
   input  logic              wb_allowin,
   output logic              mem_to_wb_valid,
   output logic [31:0]       mem_to_wb_pc,
   output logic              mem_rf_we,
   output logic [4:0]        mem_rf_waddr,
   output logic [31:0]       mem_rf_wdata,
   output logic [SIDE_W-1:0] mem_side,
   output logic [38:0]       mem_fwd,
   output logic              mem_ex
);

   localparam int         c_CNT_W  = $clog2(MAX_DISCARD + 1);
   localparam logic [3:0] c_OP_LDB  = 4'd0;
   localparam logic [3:0] c_OP_LDH  = 4'd1;
   localparam logic [3:0] c_OP_LDW  = 4'd2;
   localparam logic [3:0] c_OP_LDBU = 4'd8;
   localparam logic [3:0] c_OP_LDHU = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // Control registers (reset)
   state_t               r_state;
   logic                 r_mem_valid;
   logic [c_CNT_W-1:0]   r_discard_cnt;
   logic                 r_buf_valid;

   // Payload registers (not reset)
   logic [31:0]          r_pc;
   logic [31:0]          r_result;
   logic [3:0]           r_mem_op;
   logic                 r_is_load;
   logic                 r_rf_we;
   logic [4:0]           r_rf_waddr;
   logic [SIDE_W-1:0]    r_side;
   logic [31:0]          r_buf_data;

   // Combinational
   state_t               w_state_nxt;
   logic                 w_ready_go;
   logic                 w_live_ok;
   logic                 w_drop;
   logic                 w_accept;
   logic                 w_leave;
   logic                 w_cnt_inc;
   logic [c_CNT_W-1:0]   w_cnt_nxt;
   logic [31:0]          w_load_word;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [31:0]          w_load_ext;
   logic [31:0]          w_wdata;
   logic                 w_stall_load;

   // A response only belongs to the current instruction once every stale
   // response ahead of it has been consumed.
   assign w_live_ok = data_sram_data_ok & (r_discard_cnt == '0);
   assign w_drop    = data_sram_data_ok & (r_discard_cnt != '0);

   assign mem_allowin = ~r_mem_valid | (w_ready_go & wb_allowin);
   assign w_accept    = exe_to_mem_valid & mem_allowin;
   assign w_leave     = r_mem_valid & w_ready_go & wb_allowin;

   // A flushed instruction still waiting on its response leaves that
   // response in flight; it must be swallowed when it eventually arrives.
   assign w_cnt_inc = flush & (r_state == S_WAIT) & ~w_live_ok;

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next state and ready_go
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_ready_go  = 1'b1;

      case (r_state)
         S_WAIT:  w_ready_go = w_live_ok;
         default: w_ready_go = 1'b1;
      endcase

      if (flush) begin
         w_state_nxt = S_IDLE;
      end else if (w_accept) begin
         w_state_nxt = exe_req_sent ? S_WAIT : S_IDLE;
      end else begin
         case (r_state)
            S_WAIT: begin
               if (w_live_ok) begin
                  w_state_nxt = wb_allowin ? S_IDLE : S_HOLD;
               end
            end
            S_HOLD: begin
               if (wb_allowin) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Discard counter next value: a flush-increment and a drop in the same
   // cycle cancel out.
   //---------------------------------------------------------------------------
   always_comb begin
      w_cnt_nxt = r_discard_cnt;
      if (w_cnt_inc && !w_drop) begin
         w_cnt_nxt = r_discard_cnt + c_CNT_W'(1);
      end else if (!w_cnt_inc && w_drop) begin
         w_cnt_nxt = r_discard_cnt - c_CNT_W'(1);
      end
   end

   //---------------------------------------------------------------------------
   // Control registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_mem_valid   <= 1'b0;
         r_discard_cnt <= '0;
         r_buf_valid   <= 1'b0;
      end else begin
         if (flush) begin
            r_mem_valid <= 1'b0;
         end else if (w_accept) begin
            r_mem_valid <= 1'b1;
         end else if (w_leave) begin
            r_mem_valid <= 1'b0;
         end
         r_discard_cnt <= w_cnt_nxt;
         r_buf_valid   <= (w_state_nxt == S_HOLD);
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && w_cnt_inc && !w_drop) begin
         assert (r_discard_cnt != c_CNT_W'(MAX_DISCARD));
      end
   end

   //---------------------------------------------------------------------------
   // Payload and response buffer
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pc       <= exe_pc;
         r_result   <= exe_result;
         r_mem_op   <= exe_mem_op;
         r_is_load  <= exe_is_load;
         r_rf_we    <= exe_rf_we;
         r_rf_waddr <= exe_rf_waddr;
         r_side     <= exe_side;
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == S_WAIT) && w_live_ok && !wb_allowin) begin
         r_buf_data <= data_sram_rdata;
      end
   end

   //---------------------------------------------------------------------------
   // Load alignment and extension
   //---------------------------------------------------------------------------
   assign w_load_word = r_buf_valid ? r_buf_data : data_sram_rdata;
   assign w_half      = r_result[1] ? w_load_word[31:16] : w_load_word[15:0];

   always_comb begin
      case (r_result[1:0])
         2'd0:    w_byte = w_load_word[7:0];
         2'd1:    w_byte = w_load_word[15:8];
         2'd2:    w_byte = w_load_word[23:16];
         default: w_byte = w_load_word[31:24];
      endcase
   end

   always_comb begin
      case (r_mem_op)
         c_OP_LDB:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         c_OP_LDBU: w_load_ext = {24'd0, w_byte};
         c_OP_LDH:  w_load_ext = {{16{w_half[15]}}, w_half};
         c_OP_LDHU: w_load_ext = {16'd0, w_half};
         c_OP_LDW:  w_load_ext = w_load_word;
         default:   w_load_ext = 32'd0;
      endcase
   end

   assign w_wdata      = r_is_load ? w_load_ext : r_result;
   assign w_stall_load = r_mem_valid & r_is_load & ~w_ready_go;

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign mem_to_wb_valid = r_mem_valid & w_ready_go;
   assign mem_to_wb_pc    = r_pc;
   assign mem_rf_we       = r_rf_we;
   assign mem_rf_waddr    = r_rf_waddr;
   assign mem_rf_wdata    = w_wdata;
   assign mem_side        = r_side;
   assign mem_fwd         = {r_mem_valid & r_rf_we, w_stall_load, r_rf_waddr, w_wdata};
   assign mem_ex          = r_mem_valid & r_side[0];

endmodule

`default_nettype wire
